char_console_ctrl: RTL and testbench
====================================

# char_console_ctrl

Sequencing controller for the 64-cell character display buffer, which has a single write port (we, wr_addr, din). It accepts a stream of character codes over a valid/ready handshake, tracks a cursor, and turns printable characters, newline, backspace and clear-screen into buffer writes. The buffer is 4 rows × 16 columns, linear address = row×16 + col. This block is the only write master of the buffer.

## Interface
- FILL_CHAR, 8'h00, code written to blanked cells; instantiation binds it to the shared `Null` code.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_char is valid
- in_ready  out  1  block accepts in_char this cycle
- in_char  in  8  character or control code
- clr_req  in  1  single-cycle clear-screen request
- we  out  1  buffer write enable, registered
- wr_addr  out  6  buffer write address, registered
- din  out  8  buffer write data, registered
- cursor  out  6  current cursor address
- busy  out  1  high while a fill sequence runs (state FILL)

## Operation
- Control codes: NL = 8'h0A, BS = 8'h08, FF = 8'h0C. Every other code is printable.
- Two states: IDLE and FILL. FILL also holds a 6-bit fill end address.
- in_ready = (state==IDLE) && !clr_req, combinational. A transfer occurs when in_valid && in_ready.
- Printable char c accepted:
  - write c at cursor;
  - cursor <= cursor+1, mod 64 (63 wraps to 0);
  - state stays IDLE.
- BS accepted:
  - if cursor != 0: write FILL_CHAR at cursor-1, then cursor <= cursor-1.
  - if cursor == 0: no write, no cursor change.
- NL accepted: enter FILL and blank from cursor to the end of the current row (cursor|15). On completion, cursor <= start of the next row; row 3 wraps to 0.
- FF accepted, or clr_req high on any edge: enter FILL with range 0..63. On completion, cursor <= 0.
- clr_req has priority in every state:
  - an in-progress NL fill is abandoned and the full clear restarts at address 0;
  - clr_req during a clear restarts it at 0.
- In FILL, each cycle: we=1, din=FILL_CHAR, wr_addr steps +1. When wr_addr equals the end address, the next edge returns to IDLE with we=0.
- Non-accepted cycles in IDLE: we <= 0. wr_addr and din hold their last values.
- Reset values: we=0, wr_addr=0, din=0, cursor=0, state=IDLE, busy=0. in_ready=1 once rst is low and clr_req is low.
- Reset mid-operation aborts any fill immediately. No pending state survives reset.

## Timing
- Printable or BS accepted at edge N: we=1 with the corresponding address/data during cycle N→N+1. The cursor update is visible in the same cycle.
- Back-to-back printables produce one write per cycle. in_ready stays high.
- NL accepted at column c: exactly 16−c consecutive write cycles, starting in the cycle after acceptance. in_ready and busy are low for exactly those cycles.
- Clear: exactly 64 consecutive write cycles, addresses 0..63. in_ready is low from the cycle clr_req is sampled through the last write.
- The first cycle after the last fill write is IDLE, and a character can be accepted in that cycle.
- No combinational path from in_valid or in_char to any output. clr_req→in_ready is the only combinational path.

## Structure
- Shared package char_console_pkg holds:
  - control-code constants NL/BS/FF;
  - COLS=16 and ROWS=4;
  - the state encoding.
- Fill characters come from the existing shared character definitions.
- A single module. The fill counter and cursor logic are inline. No sub-module is warranted.

## Test plan
- After reset, send 8'h48, 8'h69 back-to-back → writes (addr 0, 8'h48) and (addr 1, 8'h69) in consecutive cycles; cursor=2; in_ready never drops.
- Cursor=5, send NL → 11 writes of 8'h00 to addr 5..15; in_ready low for exactly 11 cycles; cursor=16.
- Send 64 printables → last write to addr 63, cursor=0. Then move cursor to 48 and send NL → fills 48..63, cursor=0.
- Cursor=3, send BS → one write (addr 2, 8'h00), cursor=2. At cursor=0, BS → no write, cursor stays 0.
- Cursor=2, NL fill in progress, pulse clr_req after 3 fill writes → writes restart at 0 and run 64 cycles, cursor=0. A char held on in_valid during the clr_req cycle is not accepted there; it is accepted in the first IDLE cycle after the clear.
- Assert rst during a clear → we=0 and cursor=0 immediately (asynchronously). After release, a printable writes to addr 0.

Source files
------------

// File: rtl/char_console_pkg.sv
// Shared definitions for the character console: control codes, screen geometry,
// sequencer state encoding and the shared Null fill character.
package char_console_pkg;

    localparam logic [7:0] NL = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    // Shared Null code used for blanked display cells
    localparam logic [7:0] CHAR_NULL = 8'h00;

    localparam int COLS = 16;
    localparam int ROWS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/char_console_ctrl.sv
// Write sequencer for the 4x16 character buffer: places printable characters at the
// cursor, handles backspace, and runs blanking fills for newline and clear-screen.
module char_console_ctrl
    import char_console_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = CHAR_NULL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic       clr_req,
    output logic       we,
    output logic [5:0] wr_addr,
    output logic [7:0] din,
    output logic [5:0] cursor,
    output logic       busy
);

    localparam logic [5:0] LAST_CELL = 6'(COLS * ROWS - 1);
    localparam logic [5:0] ROW_LAST  = 6'(COLS - 1);

    state_t     state;
    logic [5:0] end_addr;

    assign in_ready = (state == IDLE) && !clr_req;
    assign busy     = (state == FILL);

    // A fill always ends on a row's last cell, so end_addr+1 is the next cursor
    // for both newline (next row start) and clear (wraps to 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            end_addr <= '0;
            we       <= 1'b0;
            wr_addr  <= '0;
            din      <= '0;
            cursor   <= '0;
        end else if (clr_req) begin
            state    <= FILL;
            end_addr <= LAST_CELL;
            we       <= 1'b1;
            wr_addr  <= '0;
            din      <= FILL_CHAR;
        end else begin
            case (state)
                IDLE: begin
                    we <= 1'b0;
                    if (in_valid) begin
                        case (in_char)
                            NL: begin
                                state    <= FILL;
                                end_addr <= cursor | ROW_LAST;
                                we       <= 1'b1;
                                wr_addr  <= cursor;
                                din      <= FILL_CHAR;
                            end
                            FF: begin
                                state    <= FILL;
                                end_addr <= LAST_CELL;
                                we       <= 1'b1;
                                wr_addr  <= '0;
                                din      <= FILL_CHAR;
                            end
                            BS: begin
                                if (cursor != 6'd0) begin
                                    we      <= 1'b1;
                                    wr_addr <= cursor - 6'd1;
                                    din     <= FILL_CHAR;
                                    cursor  <= cursor - 6'd1;
                                end
                            end
                            default: begin
                                we      <= 1'b1;
                                wr_addr <= cursor;
                                din     <= in_char;
                                cursor  <= cursor + 6'd1;
                            end
                        endcase
                    end
                end
                FILL: begin
                    if (wr_addr == end_addr) begin
                        state  <= IDLE;
                        we     <= 1'b0;
                        cursor <= end_addr + 6'd1;
                    end else begin
                        wr_addr <= wr_addr + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_console_ctrl.sv
// Directed self-checking bench for char_console_ctrl: printables, newline, backspace,
// clear priority over a running fill, and asynchronous reset during a clear.
module tb_char_console_ctrl;
    import char_console_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       clr_req = 1'b0;
    logic       in_ready;
    logic       we;
    logic [5:0] wr_addr;
    logic [7:0] din;
    logic [5:0] cursor;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    char_console_ctrl #(.FILL_CHAR(CHAR_NULL)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .clr_req  (clr_req),
        .we       (we),
        .wr_addr  (wr_addr),
        .din      (din),
        .cursor   (cursor),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        in_char  = c;
        step();
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; expects n blanking writes from base.
    task automatic check_fill(input string tag, input int base, input int n, input int cursor_after);
        for (int i = 0; i < n; i++) begin
            check({tag, "_we"}, 32'(we), 32'd1);
            check({tag, "_addr"}, 32'(wr_addr), 32'(base + i));
            check({tag, "_din"}, 32'(din), 32'h00);
            check({tag, "_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            step();
        end
        check({tag, "_done_we"}, 32'(we), 32'd0);
        check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_cursor"}, 32'(cursor), 32'(cursor_after));
    endtask

    initial begin
        repeat (2) step();
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_din", 32'(din), 32'd0);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        step();

        // Back-to-back printables
        in_valid = 1'b1;
        in_char  = 8'h48;
        step();
        check("p0_we", 32'(we), 32'd1);
        check("p0_addr", 32'(wr_addr), 32'd0);
        check("p0_din", 32'(din), 32'h48);
        check("p0_ready", 32'(in_ready), 32'd1);
        in_char = 8'h69;
        step();
        check("p1_we", 32'(we), 32'd1);
        check("p1_addr", 32'(wr_addr), 32'd1);
        check("p1_din", 32'(din), 32'h69);
        check("p1_cursor", 32'(cursor), 32'd2);
        check("p1_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        check("idle_we", 32'(we), 32'd0);
        check("idle_addr_hold", 32'(wr_addr), 32'd1);
        check("idle_din_hold", 32'(din), 32'h69);

        // Newline from column 5
        send(8'h41);
        send(8'h42);
        send(8'h43);
        check("nl5_start_cursor", 32'(cursor), 32'd5);
        send(NL);
        check_fill("nl5", 5, 11, 16);

        // Bring cursor to 0, then a full 64-cell pass
        in_valid = 1'b1;
        in_char  = 8'h2A;
        repeat (48) step();
        in_valid = 1'b0;
        check("wrap_cursor", 32'(cursor), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_char = 8'(8'h20 + i);
            step();
            check("p64_we", 32'(we), 32'd1);
            check("p64_addr", 32'(wr_addr), 32'(i));
            check("p64_din", 32'(din), 32'(8'h20 + i));
        end
        in_valid = 1'b0;
        check("p64_cursor", 32'(cursor), 32'd0);

        // Newline on the last row wraps to 0
        in_valid = 1'b1;
        in_char  = 8'h30;
        repeat (48) step();
        in_valid = 1'b0;
        check("row3_cursor", 32'(cursor), 32'd48);
        send(NL);
        check_fill("nl48", 48, 16, 0);

        // Backspace
        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(BS);
        check("bs_we", 32'(we), 32'd1);
        check("bs_addr", 32'(wr_addr), 32'd2);
        check("bs_din", 32'(din), 32'h00);
        check("bs_cursor", 32'(cursor), 32'd2);
        send(BS);
        send(BS);
        check("bs1_cursor", 32'(cursor), 32'd0);
        send(BS);
        check("bs0_we", 32'(we), 32'd0);
        check("bs0_cursor", 32'(cursor), 32'd0);

        // Clear preempts a newline fill; held char waits until after the clear
        send(8'h70);
        send(8'h71);
        send(NL);
        check("nlc_addr0", 32'(wr_addr), 32'd2);
        step();
        check("nlc_addr1", 32'(wr_addr), 32'd3);
        step();
        check("nlc_addr2", 32'(wr_addr), 32'd4);
        clr_req  = 1'b1;
        in_valid = 1'b1;
        in_char  = 8'h5A;
        #1;
        check("clr_ready_comb", 32'(in_ready), 32'd0);
        step();
        clr_req = 1'b0;
        check_fill("clr", 0, 64, 0);
        step();
        check("post_clr_we", 32'(we), 32'd1);
        check("post_clr_addr", 32'(wr_addr), 32'd0);
        check("post_clr_din", 32'(din), 32'h5A);
        check("post_clr_cursor", 32'(cursor), 32'd1);
        in_valid = 1'b0;

        // Asynchronous reset in the middle of a clear
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (4) step();
        check("mid_clr_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_we", 32'(we), 32'd0);
        check("arst_cursor", 32'(cursor), 32'd0);
        check("arst_addr", 32'(wr_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        step();
        send(8'h51);
        check("after_rst_we", 32'(we), 32'd1);
        check("after_rst_addr", 32'(wr_addr), 32'd0);
        check("after_rst_din", 32'(din), 32'h51);
        check("after_rst_cursor", 32'(cursor), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
